// File: rtl/prog_loader.sv
// Program loader: parses a SYNC/LEN/DATA/CHK byte stream, writes each data byte
// into program memory, and holds the CPU until a frame with a good checksum lands.
module prog_loader #(
    parameter int         ADDR_W        = 4,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         TIMEOUT       = 255,
    parameter logic       HOLD_AT_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [7:0]        prog_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam int LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_LEN  = 2'd1,
        S_DATA = 2'd2,
        S_CHK  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [7:0]        chk_q, chk_d;
    logic [CNT_W-1:0]  tcnt_q, tcnt_d;
    logic              prog_we_q, prog_we_d;
    logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
    logic [7:0]        prog_data_q, prog_data_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic              accept_s;
    logic              len_ok_s;
    logic              to_hit_s;
    logic [7:0]        chk_sum_s;

    // Next-state, datapath and output decode for the frame parser
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        chk_d       = chk_q;
        tcnt_d      = tcnt_q;
        prog_we_d   = 1'b0;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        cpu_hold_d  = cpu_hold_q;
        load_done_d = 1'b0;
        load_err_d  = load_err_q;
        words_d     = words_q;

        accept_s  = in_valid;
        len_ok_s  = (in_data != 8'd0) && ({24'd0, in_data} <= 32'(2 ** ADDR_W));
        chk_sum_s = chk_q + in_data;
        // An accepted byte always beats an expiring timeout
        to_hit_s  = (TIMEOUT > 0) && (state_q != S_SYNC) && !accept_s && (tcnt_q == TO_LAST);

        if ((state_q == S_SYNC) || accept_s || to_hit_s) begin
            tcnt_d = {CNT_W{1'b0}};
        end else if (TIMEOUT > 0) begin
            tcnt_d = tcnt_q + CNT_W'(1);
        end else begin
            tcnt_d = {CNT_W{1'b0}};
        end

        case (state_q)
            S_SYNC: begin
                if (accept_s && (in_data == SYNC_BYTE)) begin
                    state_d    = S_LEN;
                    cpu_hold_d = 1'b1;
                    load_err_d = 1'b0;
                    words_d    = {LEN_W{1'b0}};
                end else begin
                    state_d = S_SYNC;
                end
            end
            S_LEN: begin
                if (accept_s) begin
                    if (len_ok_s) begin
                        len_d   = LEN_W'(in_data);
                        chk_d   = in_data;
                        state_d = S_DATA;
                    end else begin
                        load_err_d = 1'b1;
                        state_d    = S_SYNC;
                    end
                end else if (to_hit_s) begin
                    load_err_d = 1'b1;
                    state_d    = S_SYNC;
                end else begin
                    state_d = S_LEN;
                end
            end
            S_DATA: begin
                if (accept_s) begin
                    chk_d       = chk_sum_s;
                    prog_we_d   = 1'b1;
                    prog_addr_d = words_q[ADDR_W-1:0];
                    prog_data_d = in_data;
                    words_d     = words_q + LEN_W'(1);
                    if ((words_q + LEN_W'(1)) == len_q) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (to_hit_s) begin
                    load_err_d = 1'b1;
                    state_d    = S_SYNC;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CHK: begin
                if (accept_s) begin
                    state_d = S_SYNC;
                    if (chk_sum_s == 8'd0) begin
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end else if (to_hit_s) begin
                    load_err_d = 1'b1;
                    state_d    = S_SYNC;
                end else begin
                    state_d = S_CHK;
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_SYNC;
            len_q       <= {LEN_W{1'b0}};
            chk_q       <= 8'd0;
            tcnt_q      <= {CNT_W{1'b0}};
            prog_we_q   <= 1'b0;
            prog_addr_q <= {ADDR_W{1'b0}};
            prog_data_q <= 8'd0;
            cpu_hold_q  <= HOLD_AT_RESET;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            words_q     <= {LEN_W{1'b0}};
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            chk_q       <= chk_d;
            tcnt_q      <= tcnt_d;
            prog_we_q   <= prog_we_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            words_q     <= words_d;
        end
    end

    assign in_ready     = 1'b1;
    assign prog_we      = prog_we_q;
    assign prog_addr    = prog_addr_q;
    assign prog_data    = prog_data_q;
    assign cpu_hold     = cpu_hold_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a byte-stream frame parser model predicts the
// memory writes, done pulses and final status flags for each stimulus stream.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;
    logic [4:0] words_loaded;

    always #5 clk = ~clk;

    prog_loader #(
        .ADDR_W(4), .SYNC_BYTE(8'hA5), .TIMEOUT(4), .HOLD_AT_RESET(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .cpu_hold(cpu_hold), .load_done(load_done),
        .load_err(load_err), .words_loaded(words_loaded)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed side
    logic [11:0] obs_q[$];
    int          done_cnt = 0;
    logic        acc_prev = 1'b0;
    logic [7:0]  data_prev = 8'd0;

    always @(posedge clk) begin
        acc_prev  <= in_valid;
        data_prev <= in_data;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (prog_we) begin
                obs_q.push_back({prog_addr, prog_data});
                check_val("wr_latency", {23'd0, acc_prev, data_prev}, {23'd0, 1'b1, prog_data});
            end
            if (load_done) begin
                done_cnt++;
                check_val("hold_drops_with_done", cpu_hold, 0);
            end
        end
    end

    // Reference model: frame-level parse of the byte stream
    logic [11:0] exp_q[$];
    int          exp_done = 0;
    bit          exp_err = 1'b0;
    bit          exp_hold = 1'b1;
    int          exp_words = 0;

    task automatic model_stream(input logic [7:0] s[$]);
        int i;
        int n;
        int len;
        int sum;
        i = 0;
        n = s.size();
        while (i < n) begin
            if (s[i] != 8'hA5) begin
                i++;
                continue;
            end
            exp_hold  = 1'b1;
            exp_err   = 1'b0;
            exp_words = 0;
            if (i + 1 >= n) break;
            len = int'(s[i+1]);
            if (len == 0 || len > 16) begin
                exp_err = 1'b1;
                i += 2;
                continue;
            end
            sum = len;
            for (int k = 0; k < len && (i + 2 + k) < n; k++) begin
                exp_q.push_back({4'(k), s[i+2+k]});
                sum += int'(s[i+2+k]);
                exp_words++;
            end
            if (i + 2 + len >= n) break;
            if (((sum + int'(s[i+2+len])) % 256) == 0) begin
                exp_done++;
                exp_hold = 1'b0;
            end else begin
                exp_err = 1'b1;
            end
            i += 3 + len;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int max_gap);
        foreach (s[i]) begin
            send_byte(s[i]);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic compare(input string tag);
        idle(2);
        check_val({tag, "_nwr"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check_val({tag, "_wr"}, obs_q[i], exp_q[i]);
        check_val({tag, "_done"}, done_cnt, exp_done);
        check_val({tag, "_err"}, load_err, exp_err);
        check_val({tag, "_hold"}, cpu_hold, exp_hold);
        check_val({tag, "_words"}, words_loaded, exp_words);
        obs_q.delete();
        exp_q.delete();
        done_cnt = 0;
        exp_done = 0;
    endtask

    task automatic run(input string tag, input logic [7:0] s[$], input int max_gap);
        model_stream(s);
        send_stream(s, max_gap);
        compare(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_we"}, prog_we, 0);
        check_val({tag, "_addr"}, prog_addr, 0);
        check_val({tag, "_data"}, prog_data, 0);
        check_val({tag, "_hold"}, cpu_hold, 1);
        check_val({tag, "_done"}, load_done, 0);
        check_val({tag, "_err"}, load_err, 0);
        check_val({tag, "_words"}, words_loaded, 0);
        check_val({tag, "_ready"}, in_ready, 1);
    endtask

    logic [7:0] fr[$];
    logic [7:0] good1[$];

    initial begin
        good1 = {8'hA5, 8'h03, 8'h12, 8'h34, 8'h56, 8'h61};

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        run("good", good1, 0);
        run("badchk", {8'hA5, 8'h03, 8'h12, 8'h34, 8'h56, 8'h62}, 0);
        run("good_after_bad", good1, 0);

        run("len0", {8'hA5, 8'h00}, 0);
        run("len17", {8'hA5, 8'h11}, 0);
        fr = {8'hA5, 8'h10};
        for (int i = 0; i < 16; i++) fr.push_back(8'h01);
        fr.push_back(8'hE0);
        run("len16", fr, 0);

        run("garbage_gaps", {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7C, 8'h83}, 3);

        // Four idle cycles mid-frame expire the timeout
        fr = {8'hA5, 8'h02, 8'h11};
        model_stream(fr);
        send_stream(fr, 0);
        idle(4);
        exp_err = 1'b1;
        compare("timeout");
        run("after_timeout", {8'hA5, 8'h01, 8'h7C, 8'h83}, 0);
        fr = {8'hA5, 8'h02, 8'h11};
        model_stream(fr);
        send_stream(fr, 0);
        idle(3);
        fr = {8'h22, 8'hCB};
        model_stream({8'hA5, 8'h02, 8'h11, 8'h22, 8'hCB});
        exp_q.delete();
        exp_q.push_back({4'd0, 8'h11});
        exp_q.push_back({4'd1, 8'h22});
        send_stream(fr, 0);
        compare("timeout_edge");

        // Reset in the middle of a frame
        send_stream({8'hA5, 8'h03, 8'h12}, 0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        obs_q.delete();
        exp_q.delete();
        done_cnt  = 0;
        exp_done  = 0;
        exp_hold  = 1'b1;
        exp_err   = 1'b0;
        exp_words = 0;
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        run("after_rst", good1, 0);

        // Random frames, some with bad checksum, bad length or garbage prefix
        for (int f = 0; f < 25; f++) begin
            int len;
            int sum;
            logic [7:0] b;
            fr.delete();
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                fr.push_back(b);
            end
            fr.push_back(8'hA5);
            if ($urandom_range(0, 7) == 0) begin
                fr.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)));
            end else begin
                len = $urandom_range(1, 16);
                fr.push_back(8'(len));
                sum = len;
                for (int k = 0; k < len; k++) begin
                    b = 8'($urandom);
                    fr.push_back(b);
                    sum += int'(b);
                end
                b = 8'((256 - (sum % 256)) % 256);
                if ($urandom_range(0, 3) == 0) b = b + 8'($urandom_range(1, 255));
                fr.push_back(b);
            end
            run("rand", fr, 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
